// File: rtl/lock_pkg.sv
// Shared lock-box constants: default code geometry used by keypad/display
// modules, the verifier state encoding and a counter width helper.
package lock_pkg;

    localparam int DEFAULT_DIGIT_W    = 3;
    localparam int DEFAULT_NUM_DIGITS = 3;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [STATE_W-1:0] ST_OPEN    = 2'd1;
    localparam logic [STATE_W-1:0] ST_PROG    = 2'd2;
    localparam logic [STATE_W-1:0] ST_LOCKOUT = 2'd3;

    // Bits needed to hold 0..max_value-1, never narrower than one bit.
    function automatic int count_width(input int max_value);
        return (max_value > 1) ? $clog2(max_value) : 1;
    endfunction

endpackage

// File: rtl/lock_code_verifier_lockout_timer.sv
// Lockout down-counter: load starts a run of exactly LOCKOUT_CYCLES cycles,
// done pulses for one cycle on the last of them.
module lockout_timer
    import lock_pkg::*;
#(
    parameter int LOCKOUT_CYCLES = 300_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int TIMER_W = count_width(LOCKOUT_CYCLES);

    logic [TIMER_W-1:0] count;
    logic               running;

    assign done = running && (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            running <= 1'b0;
        end else if (load) begin
            count   <= TIMER_W'(LOCKOUT_CYCLES - 1);
            running <= 1'b1;
        end else if (running) begin
            if (count == '0)
                running <= 1'b0;
            else
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/lock_code_verifier.sv
// Code-entry verifier: checks keyed digits against the stored code, unlocks
// on match, enforces a timed lockout after repeated failures, reprograms while open.
module lock_code_verifier
    import lock_pkg::*;
#(
    parameter int DIGIT_W        = DEFAULT_DIGIT_W,
    parameter int NUM_DIGITS     = DEFAULT_NUM_DIGITS,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 300_000_000,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = '0
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               en_valid,
    input  logic [DIGIT_W-1:0]                 en_digit,
    input  logic                               clear,
    input  logic                               lock,
    input  logic                               prog_valid,
    input  logic [DIGIT_W-1:0]                 prog_digit,
    output logic                               unlocked,
    output logic                               fail,
    output logic                               locked_out,
    output logic                               prog_done,
    output logic [$clog2(NUM_DIGITS+1)-1:0]    digit_count,
    output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count
);

    localparam int CODE_W = NUM_DIGITS * DIGIT_W;
    localparam int DCW    = $clog2(NUM_DIGITS + 1);
    localparam int FCW    = $clog2(MAX_FAILS + 1);
    localparam logic [DCW-1:0] LAST_DIGIT = DCW'(NUM_DIGITS - 1);
    localparam logic [FCW-1:0] FAIL_LIMIT = FCW'(MAX_FAILS);

    logic [STATE_W-1:0] state;
    logic [CODE_W-1:0]  code;
    logic [CODE_W-1:0]  shadow;
    logic [CODE_W-1:0]  shadow_next;
    logic               mismatch;
    logic               digit_wrong;
    logic               final_digit;
    logic               entry_done;
    logic               entry_ok;
    logic               fail_limit_hit;
    logic               timer_load;
    logic               timer_done;
    logic [DCW-1:0]     prog_index;

    assign digit_wrong    = en_digit != code[digit_count*DIGIT_W +: DIGIT_W];
    assign final_digit    = digit_count == LAST_DIGIT;
    assign entry_done     = (state == ST_IDLE) && en_valid && !clear && final_digit;
    assign entry_ok       = !mismatch && !digit_wrong;
    assign fail_limit_hit = fail_count == (FAIL_LIMIT - 1'b1);
    assign timer_load     = entry_done && !entry_ok && fail_limit_hit;

    // The first programming digit arrives while still OPEN and always lands in slot 0.
    assign prog_index = (state == ST_OPEN) ? '0 : digit_count;

    always_comb begin
        shadow_next = shadow;
        shadow_next[prog_index*DIGIT_W +: DIGIT_W] = prog_digit;
    end

    lockout_timer #(
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) u_lockout_timer (
        .clk  (CLK),
        .rst  (RST),
        .load (timer_load),
        .done (timer_done)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            code        <= DEFAULT_CODE;
            shadow      <= '0;
            digit_count <= '0;
            fail_count  <= '0;
            mismatch    <= 1'b0;
            unlocked    <= 1'b0;
            fail        <= 1'b0;
            locked_out  <= 1'b0;
            prog_done   <= 1'b0;
        end else begin
            fail      <= 1'b0;
            prog_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear) begin
                        digit_count <= '0;
                        mismatch    <= 1'b0;
                    end else if (en_valid) begin
                        if (final_digit) begin
                            digit_count <= '0;
                            mismatch    <= 1'b0;
                            if (entry_ok) begin
                                state      <= ST_OPEN;
                                unlocked   <= 1'b1;
                                fail_count <= '0;
                            end else begin
                                fail <= 1'b1;
                                if (fail_count != FAIL_LIMIT)
                                    fail_count <= fail_count + 1'b1;
                                if (fail_limit_hit) begin
                                    state      <= ST_LOCKOUT;
                                    locked_out <= 1'b1;
                                end
                            end
                        end else begin
                            digit_count <= digit_count + 1'b1;
                            mismatch    <= mismatch | digit_wrong;
                        end
                    end
                end
                ST_OPEN, ST_PROG: begin
                    if (lock) begin
                        state       <= ST_IDLE;
                        unlocked    <= 1'b0;
                        shadow      <= '0;
                        digit_count <= '0;
                    end else if (clear && state == ST_PROG) begin
                        state       <= ST_OPEN;
                        shadow      <= '0;
                        digit_count <= '0;
                    end else if (prog_valid) begin
                        shadow <= shadow_next;
                        if (prog_index == LAST_DIGIT) begin
                            code        <= shadow_next;
                            prog_done   <= 1'b1;
                            digit_count <= '0;
                            state       <= ST_OPEN;
                        end else begin
                            digit_count <= prog_index + 1'b1;
                            state       <= ST_PROG;
                        end
                    end
                end
                ST_LOCKOUT: begin
                    if (timer_done) begin
                        state       <= ST_IDLE;
                        locked_out  <= 1'b0;
                        fail_count  <= '0;
                        digit_count <= '0;
                        mismatch    <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lock_code_verifier.sv
// Randomised and scenario-driven bench for lock_code_verifier, checked against
// a queue-based model of code entry, programming and lockout.
module tb_lock_code_verifier;

    localparam int DW = 3;
    localparam int ND = 3;
    localparam int MF = 3;
    localparam int LC = 20;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         en_valid = 1'b0;
    logic [DW-1:0] en_digit = '0;
    logic         clear = 1'b0;
    logic         lock = 1'b0;
    logic         prog_valid = 1'b0;
    logic [DW-1:0] prog_digit = '0;
    logic         unlocked;
    logic         fail;
    logic         locked_out;
    logic         prog_done;
    logic [1:0]   digit_count;
    logic [1:0]   fail_count;

    int checks_done = 0;
    int checks_passed = 0;

    int ref_code[ND];
    int entered[$];
    int prog_buf[$];
    bit m_open;
    bit m_prog;
    int lock_left;
    int fails;
    bit exp_fail;
    bit exp_done;

    lock_code_verifier #(
        .DIGIT_W(DW),
        .NUM_DIGITS(ND),
        .MAX_FAILS(MF),
        .LOCKOUT_CYCLES(LC),
        .DEFAULT_CODE('0)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .en_valid(en_valid),
        .en_digit(en_digit),
        .clear(clear),
        .lock(lock),
        .prog_valid(prog_valid),
        .prog_digit(prog_digit),
        .unlocked(unlocked),
        .fail(fail),
        .locked_out(locked_out),
        .prog_done(prog_done),
        .digit_count(digit_count),
        .fail_count(fail_count)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_done++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        else
            checks_passed++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < ND; i++) ref_code[i] = 0;
        entered.delete();
        prog_buf.delete();
        m_open = 0;
        m_prog = 0;
        lock_left = 0;
        fails = 0;
        exp_fail = 0;
        exp_done = 0;
    endtask

    task automatic accept_prog(input int pd);
        prog_buf.push_back(pd);
        if (prog_buf.size() == ND) begin
            for (int i = 0; i < ND; i++) ref_code[i] = prog_buf[i];
            prog_buf.delete();
            m_prog = 0;
            exp_done = 1;
        end
    endtask

    // One clock of behaviour: what the outputs must show after this edge.
    task automatic model_step(input bit ev, input int ed, input bit clr, input bit lk, input bit pv, input int pd);
        bit ok;
        exp_fail = 0;
        exp_done = 0;
        if (lock_left > 0) begin
            lock_left--;
            if (lock_left == 0) fails = 0;
        end else if (m_prog) begin
            if (lk) begin
                prog_buf.delete();
                m_prog = 0;
                m_open = 0;
            end else if (clr) begin
                prog_buf.delete();
                m_prog = 0;
            end else if (pv) begin
                accept_prog(pd);
            end
        end else if (m_open) begin
            if (lk) m_open = 0;
            else if (pv) begin
                m_prog = 1;
                accept_prog(pd);
            end
        end else begin
            if (clr) entered.delete();
            else if (ev) begin
                entered.push_back(ed);
                if (entered.size() == ND) begin
                    ok = 1;
                    for (int i = 0; i < ND; i++) if (entered[i] != ref_code[i]) ok = 0;
                    entered.delete();
                    if (ok) begin
                        m_open = 1;
                        fails = 0;
                    end else begin
                        exp_fail = 1;
                        if (fails < MF) fails++;
                        if (fails == MF) lock_left = LC;
                    end
                end
            end
        end
    endtask

    function automatic int exp_digit_count();
        if (m_prog) return prog_buf.size();
        if (m_open || lock_left > 0) return 0;
        return entered.size();
    endfunction

    task automatic check_all();
        checkOutput("unlocked", unlocked, m_open);
        checkOutput("fail", fail, exp_fail);
        checkOutput("locked_out", locked_out, lock_left > 0);
        checkOutput("prog_done", prog_done, exp_done);
        checkOutput("digit_count", digit_count, exp_digit_count());
        checkOutput("fail_count", fail_count, fails);
    endtask

    task automatic applyStimulus(input bit ev, input int ed, input bit clr, input bit lk, input bit pv, input int pd);
        @(negedge CLK);
        en_valid   = ev;
        en_digit   = DW'(ed);
        clear      = clr;
        lock       = lk;
        prog_valid = pv;
        prog_digit = DW'(pd);
        @(posedge CLK);
        model_step(ev, ed, clr, lk, pv, pd);
        #1;
        check_all();
        en_valid   = 0;
        clear      = 0;
        lock       = 0;
        prog_valid = 0;
    endtask

    task automatic enter_code(input int d0, input int d1, input int d2);
        applyStimulus(1, d0, 0, 0, 0, 0);
        applyStimulus(1, d1, 0, 0, 0, 0);
        applyStimulus(1, d2, 0, 0, 0, 0);
    endtask

    task automatic prog_code(input int d0, input int d1, input int d2);
        applyStimulus(0, 0, 0, 0, 1, d0);
        applyStimulus(0, 0, 0, 0, 1, d1);
        applyStimulus(0, 0, 0, 0, 1, d2);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    // Reset raised between edges must clear outputs before the next clock.
    task automatic async_reset(input string tag);
        #2;
        RST = 1;
        model_reset();
        #1;
        checkOutput({tag, "_unlocked"}, unlocked, 0);
        checkOutput({tag, "_locked_out"}, locked_out, 0);
        checkOutput({tag, "_digit_count"}, digit_count, 0);
        check_all();
        @(negedge CLK);
        RST = 0;
    endtask

    initial begin
        int lock_cycles;
        int saved;
        int idx;
        int d;

        model_reset();
        RST = 1;
        #1;
        check_all();
        @(negedge CLK);
        RST = 0;

        enter_code(0, 0, 0);
        checkOutput("open_after_000", unlocked, 1);
        checkOutput("fails_after_000", fail_count, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);

        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 5, 0, 0, 0, 0);
        checkOutput("no_early_reject", fail, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("fail_after_050", fail, 1);
        checkOutput("fails_after_050", fail_count, 1);
        idle(1);
        checkOutput("fail_single_pulse", fail, 0);

        async_reset("rst_clear_fails");
        enter_code(7, 7, 7);
        enter_code(7, 7, 7);
        enter_code(7, 7, 7);
        lock_cycles = locked_out ? 1 : 0;
        for (int i = 0; i < 40 && locked_out; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0);
            if (locked_out) lock_cycles++;
        end
        checkOutput("lockout_length", lock_cycles, LC);
        checkOutput("fails_after_lockout", fail_count, 0);
        enter_code(0, 0, 0);
        checkOutput("open_after_lockout", unlocked, 1);

        prog_code(3, 6, 1);
        checkOutput("prog_done_361", prog_done, 1);
        applyStimulus(0, 0, 0, 1, 0, 0);
        enter_code(0, 0, 0);
        checkOutput("old_code_rejected", fail, 1);
        enter_code(3, 6, 1);
        checkOutput("new_code_opens", unlocked, 1);
        applyStimulus(0, 0, 0, 1, 0, 0);

        enter_code(5, 5, 5);
        saved = fail_count;
        applyStimulus(1, 3, 0, 0, 0, 0);
        applyStimulus(1, 6, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("clear_keeps_fails", fail_count, saved);
        checkOutput("clear_digit_count", digit_count, 0);
        enter_code(3, 6, 1);
        checkOutput("open_after_clear", unlocked, 1);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(1, 3, 0, 0, 0, 0);
        applyStimulus(1, 6, 1, 0, 0, 0);
        checkOutput("clear_beats_digit", digit_count, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);

        enter_code(7, 7, 7);
        enter_code(7, 7, 7);
        enter_code(7, 7, 7);
        idle(10);
        checkOutput("still_locked", locked_out, 1);
        async_reset("rst_lockout");
        enter_code(0, 0, 0);
        checkOutput("default_code_back", unlocked, 1);
        applyStimulus(0, 0, 0, 0, 1, 4);
        applyStimulus(0, 0, 0, 0, 1, 2);
        checkOutput("prog_two_digits", digit_count, 2);
        async_reset("rst_prog");
        enter_code(0, 0, 0);
        checkOutput("prog_discarded", unlocked, 1);

        for (int i = 0; i < 800; i++) begin
            idx = entered.size();
            if (idx < ND && $urandom_range(0, 9) < 7) d = ref_code[idx];
            else d = $urandom_range(0, 7);
            applyStimulus($urandom_range(0, 1) == 1, d,
                          $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 6,
                          $urandom_range(0, 99) < 25, $urandom_range(0, 7));
        end

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_done);
        $finish;
    end

endmodule
